pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//   Program-counter sequencer for the fetch stage. Owns the PC register and time-shares the
//   single 16-bit PC adder between the sequential increment (PC+2) and PC-relative branch
//   target generation (PC+2 + imm<<1). Register-indirect branches, halt and stall are handled
//   here as well. Output pc drives instruction-memory address and pc_plus2 drives the link path.
// PARAMETERS
//   WIDTH     16       PC / adder width
//   IMM_W     9        branch immediate width (signed, word offset)
//   RESET_PC  16'h0000 PC value loaded on reset
// PORTS
//   clk         in   1      system clock, rising edge
//   rst         in   1      synchronous reset, active-high
//   stall       in   1      freeze request from hazard unit
//   br_en       in   1      branch instruction present in decode this cycle
//   br_reg      in   1      1 = register-indirect branch (BR), 0 = PC-relative (B)
//   cond        in   3      branch condition code
//   flags       in   3      {Z,V,N} from flag register
//   imm         in   IMM_W  signed branch offset in words
//   reg_target  in   WIDTH  target for register-indirect branch
//   halt_in     in   1      HLT instruction decoded
//   pc          out  WIDTH  current PC (registered)
//   pc_plus2    out  WIDTH  PC+2 of the current instruction
//   fetch_valid out  1      1 = pc addresses a valid fetch this cycle
//   halted      out  1      processor halted (sticky until rst)
// BEHAVIOUR
//   Reset (rst=1 at edge): pc=RESET_PC, state=RUN, fetch_valid=1, halted=0, internal regs 0.
//   States: RUN, BR_ADD, HALTED. All PC updates occur on rising clk edge.
//   Adder mux: RUN -> A=pc, B=2; BR_ADD -> A=base_q, B=off_q. Carry-out discarded; sums wrap
//     mod 2^16 (0xFFFE+2=0x0000). Sub tied 0.
//   pc_plus2: RUN = adder sum (pc+2); BR_ADD = base_q.
//   Taken = br_en & condition true; conditions on {Z,V,N}:
//     000 Z=0 | 001 Z=1 | 010 Z=0&N=0 | 011 N=1 | 100 Z=1|(Z=0&N=0) | 101 N=1|Z=1
//     110 V=1 | 111 always.
//   RUN, stall=1: pc, state, regs held; all other inputs ignored; fetch_valid=1.
//   RUN, stall=0, priority highest first:
//     halt_in=1         -> HALTED, pc held (points at HLT).
//     taken & br_reg=1  -> pc<=reg_target, stay RUN (zero bubble).
//     taken & br_reg=0  -> base_q<=pc+2, off_q<=sext(imm)<<1, pc held, -> BR_ADD.
//     otherwise (incl. not-taken) -> pc<=pc+2.
//   BR_ADD: fetch_valid=0 (one bubble); stall=1 holds state; stall=0 -> pc<=base_q+off_q, RUN.
//     br_en/halt_in ignored in BR_ADD.
//   HALTED: pc frozen, halted=1, fetch_valid=0; all inputs except rst ignored.
//   Latency: sequential/BR 1 cycle; B taken 2 cycles (1 bubble).
//   rst in any state (incl. mid BR_ADD) wins over every other input; pending target discarded.
// TESTING
//   T1 reset then 4 cycles idle -> pc 0000,0002,0004,0006; fetch_valid=1, halted=0.
//   T2 pc=0010, br_en, br_reg=0, cond=111, imm=9'h004 -> next cycle pc=0010 & fetch_valid=0,
//      following cycle pc=001A.
//   T3 pc=0020, cond=001, flags Z=0 -> not taken, pc=0022; repeat with imm=9'h1FE, Z=1
//      -> pc=001E after bubble (negative offset).
//   T4 pc=0030, br_reg=1, cond=111, reg_target=1234 -> pc=1234 next cycle, no bubble;
//      same with halt_in=1 -> halted=1, pc stays 0030, unaffected by later br_en.
//   T5 pc=FFFE, idle -> pc=0000 (wrap); stall=1 for 3 cycles -> pc held; stall in BR_ADD
//      holds bubble, target applied on stall release.
//   T6 rst asserted during BR_ADD and during HALTED -> pc=0000, RUN, halted=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-stage program-counter sequencer. Owns the PC register
//               and shares one WIDTH-bit adder between the sequential PC+2
//               increment and PC-relative branch target generation
//               (PC+2 + sext(imm)<<1, computed in a second cycle).
//               Also handles register-indirect branches, halt and stall.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                WIDTH    = 16,
    parameter int                IMM_W    = 9,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_en,
    input  logic              br_reg,
    input  logic [2:0]        cond,
    input  logic [2:0]        flags,
    input  logic [IMM_W-1:0]  imm,
    input  logic [WIDTH-1:0]  reg_target,
    input  logic              halt_in,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_plus2,
    output logic              fetch_valid,
    output logic              halted
);

    // Sequencer states; BR_ADD is the single bubble cycle in which the
    // shared adder forms the PC-relative target.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BR_ADD = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_two = WIDTH'(2);

    state_t            r_state;
    logic [WIDTH-1:0]  r_pc;
    logic [WIDTH-1:0]  r_base;        // PC+2 of the branch instruction
    logic [WIDTH-1:0]  r_off;         // byte offset, sext(imm)<<1
    logic              r_fetch_valid;
    logic              r_halted;

    logic              w_flag_z;
    logic              w_flag_v;
    logic              w_flag_n;
    logic              w_cond_true;
    logic              w_taken;
    logic [WIDTH-1:0]  w_imm_sext;
    logic [WIDTH-1:0]  w_off_next;
    logic [WIDTH-1:0]  w_add_a;
    logic [WIDTH-1:0]  w_add_b;
    logic [WIDTH-1:0]  w_sum;

    assign w_flag_z = flags[2];
    assign w_flag_v = flags[1];
    assign w_flag_n = flags[0];

    // Branch condition evaluation on {Z,V,N}
    always_comb begin
        w_cond_true = 1'b0;
        case (cond)
            3'b000:  w_cond_true = ~w_flag_z;
            3'b001:  w_cond_true =  w_flag_z;
            3'b010:  w_cond_true = ~w_flag_z & ~w_flag_n;
            3'b011:  w_cond_true =  w_flag_n;
            3'b100:  w_cond_true =  w_flag_z | (~w_flag_z & ~w_flag_n);
            3'b101:  w_cond_true =  w_flag_n | w_flag_z;
            3'b110:  w_cond_true =  w_flag_v;
            3'b111:  w_cond_true =  1'b1;
            default: w_cond_true =  1'b0;
        endcase
    end

    assign w_taken = br_en & w_cond_true;

    // Word offset sign-extended to PC width, then scaled to bytes.
    assign w_imm_sext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    assign w_off_next = w_imm_sext << 1;

    // Shared adder operand select: increment in RUN, target in BR_ADD
    always_comb begin
        w_add_a = r_pc;
        w_add_b = c_two;
        if (r_state == ST_BR_ADD) begin
            w_add_a = r_base;
            w_add_b = r_off;
        end
    end

    // Carry-out is dropped, so the PC wraps modulo 2^WIDTH.
    assign w_sum = w_add_a + w_add_b;

    // State, PC and branch-operand registers with registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_pc          <= RESET_PC;
            r_base        <= '0;
            r_off         <= '0;
            r_fetch_valid <= 1'b1;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!stall) begin
                        if (halt_in) begin
                            // PC stays on the HLT instruction.
                            r_state       <= ST_HALTED;
                            r_fetch_valid <= 1'b0;
                            r_halted      <= 1'b1;
                        end else if (w_taken && br_reg) begin
                            r_pc <= reg_target;
                        end else if (w_taken) begin
                            // Adder is busy with PC+2 now; capture operands
                            // and form the target next cycle.
                            r_base        <= w_sum;
                            r_off         <= w_off_next;
                            r_state       <= ST_BR_ADD;
                            r_fetch_valid <= 1'b0;
                        end else begin
                            r_pc <= w_sum;
                        end
                    end
                end
                ST_BR_ADD: begin
                    if (!stall) begin
                        r_pc          <= w_sum;
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    r_fetch_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end
                default: begin
                    r_state       <= ST_RUN;
                    r_fetch_valid <= 1'b1;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc_plus2    = (r_state == ST_BR_ADD) ? r_base : w_sum;
    assign fetch_valid = r_fetch_valid;
    assign halted      = r_halted;

endmodule
`default_nettype wire
